// File: rtl/glyph_rom_arbiter.sv
// Two-requester round-robin burst arbiter in front of a single-port glyph ROM.
// One ROM address per READ cycle; each beat returns one cycle later (ROM read latency).
module glyph_rom_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [3:0]        len0,
    input  logic [3:0]        len1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    output logic              rom_write,
    output logic              rom_debugaccess,
    output logic [DATA_W-1:0] rom_writedata,
    input  logic [DATA_W-1:0] rom_readdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic              r_ptr;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_count;
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic              r_rsp_id;

    logic w_idle;
    logic w_read;
    logic w_grant0;
    logic w_grant1;

    assign w_idle   = (r_state == S_IDLE);
    assign w_read   = (r_state == S_READ);
    // r_ptr == 0 prefers requester 0; a lone request wins regardless of the pointer
    assign w_grant0 = w_idle && req0 && (!req1 || !r_ptr);
    assign w_grant1 = w_idle && req1 && !w_grant0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_addr      <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_state <= S_READ;
                        r_owner <= w_grant1;
                        r_addr  <= w_grant1 ? addr1 : addr0;
                        r_count <= w_grant1 ? len1 : len0;
                        r_ptr   <= w_grant0;
                    end
                end
                S_READ: begin
                    // Address stops on the final word so rom_address holds it afterwards
                    if (r_count == 4'd0) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_count <= r_count - 4'd1;
                        r_addr  <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            r_rsp_valid <= w_read;
            r_rsp_last  <= w_read && (r_count == 4'd0);
            if (w_read) begin
                r_rsp_id <= r_owner;
            end
        end
    end

    assign ack0            = reset_n && w_grant0;
    assign ack1            = reset_n && w_grant1;
    assign busy            = !w_idle;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_last        = r_rsp_last;
    assign rsp_id          = r_rsp_id;
    assign rsp_data        = r_rsp_valid ? rom_readdata : '0;
    assign rom_address     = r_addr;
    assign rom_chipselect  = w_read;
    assign rom_clken       = 1'b1;
    assign rom_write       = 1'b0;
    assign rom_debugaccess = 1'b0;
    assign rom_writedata   = '0;

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Bench for glyph_rom_arbiter: directed burst scenarios plus a per-cycle
// reference model that predicts grants, ROM addresses and returned beats.
module tb_glyph_rom_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [3:0]    len0, len1;
    logic          ack0, ack1;
    logic [DW-1:0] rsp_data;
    logic          rsp_valid, rsp_id, rsp_last, busy;
    logic [AW-1:0] rom_address;
    logic          rom_chipselect, rom_clken, rom_write, rom_debugaccess;
    logic [DW-1:0] rom_writedata;
    logic [DW-1:0] rom_rd;

    logic [DW-1:0] rom_mem [4096];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          id;
        logic          last;
    } beat_t;

    logic [AW-1:0] exp_addr [int];
    beat_t         exp_beat [int];
    int            m_free = 0;
    logic          m_ptr  = 1'b0;
    logic [AW-1:0] m_last = '0;

    glyph_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0           (req0),
        .req1           (req1),
        .addr0          (addr0),
        .addr1          (addr1),
        .len0           (len0),
        .len1           (len1),
        .ack0           (ack0),
        .ack1           (ack1),
        .rsp_data       (rsp_data),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_last       (rsp_last),
        .busy           (busy),
        .rom_address    (rom_address),
        .rom_chipselect (rom_chipselect),
        .rom_clken      (rom_clken),
        .rom_write      (rom_write),
        .rom_debugaccess(rom_debugaccess),
        .rom_writedata  (rom_writedata),
        .rom_readdata   (rom_rd)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM
    always @(posedge clk) rom_rd <= rom_mem[rom_address];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: grants by round-robin rule, then a burst is a list of
    // addresses at ack+1.. and beats at ack+2.., idle again at ack+L+2.
    always @(negedge clk) begin : model
        logic          g0, g1, e_busy;
        logic [AW-1:0] a;
        int            l;
        beat_t         b;
        if (!reset_n) begin
            exp_addr.delete();
            exp_beat.delete();
            m_free = cyc;
            m_ptr  = 1'b0;
            m_last = '0;
            n_tests++;
            if ({ack0, ack1, rsp_valid, rsp_last, rsp_id, busy, rom_chipselect} !== 7'b0 ||
                rsp_data !== '0 || rom_address !== '0) begin
                n_fail++;
                $display("FAIL mon_reset cyc=%0d ack=%b%b v=%b last=%b id=%b busy=%b cs=%b data=%h addr=%h required all 0",
                         cyc, ack0, ack1, rsp_valid, rsp_last, rsp_id, busy, rom_chipselect, rsp_data, rom_address);
            end
        end else begin
            e_busy = (cyc < m_free);
            g0 = 1'b0;
            g1 = 1'b0;
            if (!e_busy && (req0 || req1)) begin
                g0 = req0 && (!req1 || !m_ptr);
                g1 = !g0;
                a  = g0 ? addr0 : addr1;
                l  = int'(g0 ? len0 : len1) + 1;
                for (int i = 0; i < l; i++) begin
                    exp_addr[cyc + 1 + i] = a;
                    b.d    = rom_mem[a];
                    b.id   = g1;
                    b.last = (i == l - 1);
                    exp_beat[cyc + 2 + i] = b;
                    a = a + 1'b1;
                end
                m_free = cyc + l + 2;
                m_ptr  = g0;
            end
            n_tests++;
            if (ack0 !== g0 || ack1 !== g1 || busy !== e_busy) begin
                n_fail++;
                $display("FAIL mon_ctrl cyc=%0d ack0=%b ack1=%b busy=%b required %b %b %b",
                         cyc, ack0, ack1, busy, g0, g1, e_busy);
            end
            n_tests++;
            if (exp_addr.exists(cyc)) begin
                m_last = exp_addr[cyc];
                exp_addr.delete(cyc);
                if (rom_chipselect !== 1'b1 || rom_address !== m_last) begin
                    n_fail++;
                    $display("FAIL mon_addr cyc=%0d cs=%b addr=%h required cs=1 addr=%h",
                             cyc, rom_chipselect, rom_address, m_last);
                end
            end else if (rom_chipselect !== 1'b0 || rom_address !== m_last) begin
                n_fail++;
                $display("FAIL mon_addr_hold cyc=%0d cs=%b addr=%h required cs=0 addr=%h",
                         cyc, rom_chipselect, rom_address, m_last);
            end
            n_tests++;
            if (exp_beat.exists(cyc)) begin
                b = exp_beat[cyc];
                exp_beat.delete(cyc);
                if (rsp_valid !== 1'b1 || rsp_data !== b.d || rsp_id !== b.id || rsp_last !== b.last) begin
                    n_fail++;
                    $display("FAIL mon_beat cyc=%0d v=%b data=%h id=%b last=%b required v=1 data=%h id=%b last=%b",
                             cyc, rsp_valid, rsp_data, rsp_id, rsp_last, b.d, b.id, b.last);
                end
            end else if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mon_no_beat cyc=%0d rsp_valid=%b required 0", cyc, rsp_valid);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset_n = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Returns at the negedge of the ack cycle
    task automatic wait_ack(input int which, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((which == 1) ? ack1 : ack0) begin
                t  = cyc;
                ok = 1'b1;
                return;
            end
            next_cycle();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 12'h020; addr1 = 12'h040; len0 = 4'd1; len1 = 4'd1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ack0, ack1, rsp_valid, rsp_last, rsp_id, busy, rom_chipselect} !== 7'b0 ||
            rsp_data !== '0 || rom_address !== '0) begin
            n_fail++;
            $display("FAIL reset_state ack=%b%b v=%b busy=%b cs=%b addr=%h required all 0",
                     ack0, ack1, rsp_valid, busy, rom_chipselect, rom_address);
        end
        n_tests++;
        if (rom_clken !== 1'b1 || rom_write !== 1'b0 || rom_debugaccess !== 1'b0 || rom_writedata !== '0) begin
            n_fail++;
            $display("FAIL tied_outputs clken=%b write=%b dbg=%b wdata=%h required 1 0 0 00",
                     rom_clken, rom_write, rom_debugaccess, rom_writedata);
        end
        next_cycle();
        reset_n = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_grant ack0=%b ack1=%b required 1 0", ack0, ack1);
        end
        next_cycle();
        req0 = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL reset_idle busy=%b required 0", busy); end
    endtask

    task automatic test_single_burst();
        int t; bit ok; logic [AW-1:0] ea;
        next_cycle();
        req0 = 1'b1; req1 = 1'b0; addr0 = 12'h100; len0 = 4'd3;
        wait_ack(0, t, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_ack observed=none required=ack0"); end
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            req0 = 1'b0;
            @(negedge clk);
            ea = 12'h100 + 12'(k - 1);
            if (k <= 4) begin
                n_tests++;
                if (rom_chipselect !== 1'b1 || rom_address !== ea) begin
                    n_fail++;
                    $display("FAIL single_addr T+%0d cs=%b addr=%h required 1 %h", k, rom_chipselect, rom_address, ea);
                end
            end
            if (k >= 2 && k <= 5) begin
                ea = 12'h100 + 12'(k - 2);
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== rom_mem[ea] || rsp_last !== (k == 5)) begin
                    n_fail++;
                    $display("FAIL single_beat T+%0d v=%b id=%b data=%h last=%b required 1 0 %h %b",
                             k, rsp_valid, rsp_id, rsp_data, rsp_last, rom_mem[ea], (k == 5));
                end
            end
            n_tests++;
            if (busy !== (k <= 5)) begin
                n_fail++;
                $display("FAIL single_busy T+%0d busy=%b required %b", k, busy, (k <= 5));
            end
        end
    endtask

    task automatic test_both_requests();
        int t0, t1; bit ok;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 12'h200; len0 = 4'd2; addr1 = 12'h300; len1 = 4'd1;
        wait_ack(0, t0, ok);
        n_tests++;
        if (!ok || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL both_first ok=%b ack1=%b required ack0 first, ack1=0", ok, ack1);
        end
        next_cycle();
        req0 = 1'b0;
        wait_ack(1, t1, ok);
        n_tests++;
        if (!ok || t1 != t0 + 5) begin
            n_fail++;
            $display("FAIL both_second ack1 at T+%0d required T+5", t1 - t0);
        end
        next_cycle();
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, t0, ok);
        n_tests++;
        if (!ok || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL both_ptr_back ok=%b ack1=%b required ack0 preferred", ok, ack1);
        end
        next_cycle();
        req0 = 1'b0;
        wait_ack(1, t1, ok);
        next_cycle();
        req1 = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL both_idle busy=%b required 0", busy); end
    endtask

    task automatic test_wrap();
        int t; bit ok; logic [AW-1:0] ea;
        next_cycle();
        req1 = 1'b1; addr1 = 12'hFFE; len1 = 4'd3;
        wait_ack(1, t, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wrap_ack observed=none required=ack1"); end
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            req1 = 1'b0;
            @(negedge clk);
            if (k <= 4) begin
                ea = 12'hFFE + 12'(k - 1);
                n_tests++;
                if (rom_chipselect !== 1'b1 || rom_address !== ea) begin
                    n_fail++;
                    $display("FAIL wrap_addr T+%0d addr=%h required %h", k, rom_address, ea);
                end
            end
            if (k >= 2) begin
                ea = 12'hFFE + 12'(k - 2);
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== rom_mem[ea] || rsp_last !== (k == 5)) begin
                    n_fail++;
                    $display("FAIL wrap_beat T+%0d v=%b id=%b data=%h last=%b required 1 1 %h %b",
                             k, rsp_valid, rsp_id, rsp_data, rsp_last, rom_mem[ea], (k == 5));
                end
            end
        end
    endtask

    task automatic test_len0();
        int t; bit ok; logic [AW-1:0] a;
        next_cycle();
        a = 12'($urandom);
        req0 = 1'b1; addr0 = a; len0 = 4'd0;
        wait_ack(0, t, ok);
        next_cycle();
        req0 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (!ok || rom_chipselect !== 1'b1 || rom_address !== a || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_addr ok=%b cs=%b addr=%h v=%b required 1 1 %h 0", ok, rom_chipselect, rom_address, rsp_valid, a);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_data !== rom_mem[a] || rom_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_beat v=%b last=%b data=%h cs=%b required 1 1 %h 0", rsp_valid, rsp_last, rsp_data, rom_chipselect, rom_mem[a]);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_end busy=%b v=%b required 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_reset_midburst();
        int t; bit ok; bit bad;
        next_cycle();
        req0 = 1'b1; addr0 = 12'($urandom); len0 = 4'd15;
        wait_ack(0, t, ok);
        next_cycle();
        req0 = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, rsp_last, busy, rom_chipselect, ack0, ack1} !== 6'b0 || rsp_data !== '0 || rom_address !== '0) begin
            n_fail++;
            $display("FAIL midburst_abort v=%b last=%b busy=%b cs=%b data=%h addr=%h required all 0",
                     rsp_valid, rsp_last, busy, rom_chipselect, rsp_data, rom_address);
        end
        next_cycle();
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || rom_chipselect !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            next_cycle();
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL midburst_resumed activity seen after release, required none"); end
        req1 = 1'b1; addr1 = 12'($urandom); len1 = 4'd2;
        wait_ack(1, t, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL midburst_newreq observed=none required=ack1"); end
        next_cycle();
        req1 = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_alternate();
        logic last_g; logic a0, a1; int n0, n1, exp_beats, got_beats;
        do_reset();
        last_g = 1'b1;
        n0 = 0; n1 = 0; exp_beats = 0; got_beats = 0;
        req1 = 1'b1; addr1 = 12'($urandom); len1 = 4'($urandom);
        req0 = 1'b0; addr0 = 12'($urandom); len0 = 4'($urandom);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            got_beats += int'(rsp_valid);
            a0 = ack0;
            a1 = ack1;
            if (a0 || a1) begin
                if (req0 && req1) begin
                    n_tests++;
                    if (a0 === a1 || a1 !== !last_g) begin
                        n_fail++;
                        $display("FAIL alt_order cyc=%0d ack0=%b ack1=%b required ack1=%b", cyc, a0, a1, !last_g);
                    end
                end
                last_g = a1;
                exp_beats += int'(a1 ? len1 : len0) + 1;
                if (a1) n1++; else n0++;
            end
            next_cycle();
            if (a1) begin addr1 = 12'($urandom); len1 = 4'($urandom); end
            if (a0 || !req0) begin
                req0 = 1'($urandom_range(0, 1));
                addr0 = 12'($urandom);
                len0 = 4'($urandom);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            got_beats += int'(rsp_valid);
            next_cycle();
        end
        n_tests++;
        if (got_beats != exp_beats || n0 == 0 || n1 == 0) begin
            n_fail++;
            $display("FAIL alt_beats beats=%0d grants0=%0d grants1=%0d required beats=%0d, both grants >0",
                     got_beats, n0, n1, exp_beats);
        end
    endtask

    task automatic test_back_to_back();
        int prev_t, prev_l, grants; logic prev_id; logic a0, a1; bit ok;
        next_cycle();
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 12'($urandom); len0 = 4'($urandom);
        addr1 = 12'($urandom); len1 = 4'($urandom);
        grants = 0; prev_t = 0; prev_l = 0; prev_id = 1'b0;
        for (int i = 0; i < 300 && grants < 6; i++) begin
            @(negedge clk);
            a0 = ack0;
            a1 = ack1;
            if (a0 || a1) begin
                if (grants > 0) begin
                    n_tests++;
                    if (cyc - prev_t != prev_l + 2 || a1 === prev_id) begin
                        n_fail++;
                        $display("FAIL b2b_gap cyc=%0d gap=%0d id=%b required gap=%0d id=%b",
                                 cyc, cyc - prev_t, a1, prev_l + 2, !prev_id);
                    end
                end
                prev_t  = cyc;
                prev_id = a1;
                prev_l  = int'(a1 ? len1 : len0) + 1;
                grants++;
            end
            next_cycle();
            if (a0) begin addr0 = 12'($urandom); len0 = 4'($urandom); end
            if (a1) begin addr1 = 12'($urandom); len1 = 4'($urandom); end
        end
        n_tests++;
        if (grants < 6) begin n_fail++; $display("FAIL b2b_grants observed=%0d required=6", grants); end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_idle busy=%b required 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        test_reset();
        test_single_burst();
        test_both_requests();
        test_wrap();
        test_len0();
        test_reset_midburst();
        test_alternate();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
